// File: rtl/frankie_control_fsm.sv
// Multicycle control FSM for the Frankie datapath: fetch/decode/execute/memory/writeback sequencing.
// Build option: define FRANKIE_ILLEGAL_TRAP_EN to send illegal opcodes to TRAP instead of executing a NOP.
module frankie_control_fsm #(
  parameter int                OP_W    = 5,
  parameter logic [OP_W-1:0]   HALT_OP = 5'h1F
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            alu_zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      iord,
  output logic [2:0]      alu_op,
  output logic [1:0]      alu_src_b,
  output logic            reg_write,
  output logic [1:0]      wb_src,
  output logic            sp_write,
  output logic            halted,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_WB     = 4'd5,
    S_HALT   = 4'd6,
    S_TRAP   = 4'd7
  } state_t;

  localparam logic [OP_W-1:0] OP_LI   = OP_W'(8'h00);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(8'h01);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(8'h02);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(8'h03);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(8'h04);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(8'h05);
  localparam logic [OP_W-1:0] OP_PUSH = OP_W'(8'h06);
  localparam logic [OP_W-1:0] OP_POP  = OP_W'(8'h07);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(8'h08);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(8'h09);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(8'h0A);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd1;
  localparam logic [1:0] SRCB_ONE = 2'd2;

  localparam logic [1:0] IORD_PC  = 2'd0;
  localparam logic [1:0] IORD_ALU = 2'd1;
  localparam logic [1:0] IORD_SP  = 2'd2;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic            op_legal;

  assign op_legal = (opcode <= OP_BEQ) || (opcode == HALT_OP);
  assign state    = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // The IR is stable from DECODE onward; a private copy keeps later states independent of it.
  always_ff @(posedge clock) begin
    if (state_q == S_DECODE) op_q <= opcode;
  end

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = IORD_PC;
    alu_op    = ALU_ADD;
    alu_src_b = SRCB_REG;
    reg_write = 1'b0;
    wb_src    = 2'd0;
    sp_write  = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_LI)        state_d = S_WB;
        else if (opcode == HALT_OP) state_d = S_HALT;
        else if (opcode == OP_POP)  state_d = S_MEMRD;
        else if (op_legal)          state_d = S_EXEC;
        else begin
`ifdef FRANKIE_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD:  state_d = S_WB;
          OP_SUB:  begin alu_op = ALU_SUB; state_d = S_WB; end
          OP_ADDI: begin alu_src_b = SRCB_IMM; state_d = S_WB; end
          OP_LW:   begin alu_src_b = SRCB_IMM; state_d = S_MEMRD; end
          OP_SW:   begin alu_src_b = SRCB_IMM; state_d = S_MEMWR; end
          OP_PUSH: begin
            alu_op    = ALU_SUB;
            alu_src_b = SRCB_ONE;
            sp_write  = 1'b1;
            state_d   = S_MEMWR;
          end
          OP_JAL: begin
            reg_write = 1'b1;
            wb_src    = 2'd3;
            pc_write  = 1'b1;
            pc_src    = 2'd1;
            state_d   = S_FETCH;
          end
          OP_JR:  begin pc_write = 1'b1; pc_src = 2'd2; state_d = S_FETCH; end
          OP_BEQ: begin
            alu_op   = ALU_SUB;
            pc_write = alu_zero;
            pc_src   = 2'd3;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = (op_q == OP_POP) ? IORD_SP : IORD_ALU;
        if (mem_ready) state_d = S_WB;
      end
      S_MEMWR: begin
        // PUSH stores through the SP value already decremented in EXEC.
        mem_write = 1'b1;
        iord      = (op_q == OP_PUSH) ? IORD_SP : IORD_ALU;
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        if (op_q == OP_LI) wb_src = 2'd2;
        else if (op_q == OP_LW || op_q == OP_POP) wb_src = 2'd1;
        if (op_q == OP_POP) begin
          sp_write  = 1'b1;
          alu_src_b = SRCB_ONE;
        end
      end
      S_HALT, S_TRAP: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // Outputs are forced low while reset is held so a write in flight is cut immediately.
    if (!reset) begin
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      iord      = IORD_PC;
      alu_op    = ALU_ADD;
      alu_src_b = SRCB_REG;
      reg_write = 1'b0;
      wb_src    = 2'd0;
      sp_write  = 1'b0;
      halted    = 1'b0;
    end
  end

endmodule

// File: tb/tb_frankie_control_fsm.sv
// Scoreboard bench for frankie_control_fsm: per-cycle expected control vectors queued with stimulus.
module tb_frankie_control_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, sp_write, halted;
  logic [1:0] pc_src, iord, alu_src_b, wb_src;
  logic [2:0] alu_op;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       mrd;
    logic       mwr;
    logic [1:0] iord;
    logic [2:0] aop;
    logic [1:0] srcb;
    logic       rw;
    logic [1:0] wbs;
    logic       spw;
    logic       hlt;
  } ov_t;

  typedef struct packed {
    logic [4:0] op;
    logic       rdy;
    logic       z;
  } st_t;

  ov_t got;
  assign got = {state, pc_write, pc_src, ir_write, mem_read, mem_write, iord,
                alu_op, alu_src_b, reg_write, wb_src, sp_write, halted};

  ov_t exp_q[$];
  st_t stim_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  always #5 clock = ~clock;

  frankie_control_fsm #(.OP_W(5), .HALT_OP(5'h1F)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .wb_src(wb_src),
    .sp_write(sp_write), .halted(halted), .state(state)
  );

  function automatic ov_t vs(input logic [3:0] s);
    ov_t o;
    o = '0;
    o.st = s;
    return o;
  endfunction

  function automatic ov_t vfetch(input logic rdy);
    ov_t o;
    o = vs(4'd0);
    o.mrd = 1'b1;
    o.irw = rdy;
    o.pcw = rdy;
    return o;
  endfunction

  task automatic push(input logic [4:0] op, input logic rdy, input logic z, input ov_t e);
    st_t s;
    s.op = op; s.rdy = rdy; s.z = z;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; mem_ready = 1'b0;
    #2 reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; opcode = 5'h05; alu_zero = 1'b0; mem_ready = 1'b1;
    #50;
    n_chk++;
    if (got !== '0) $display("FAIL reset_mid got=%h exp=%h", got, ov_t'('0));
    else n_pass++;
    #50;
    n_chk++;
    if (got !== '0) $display("FAIL reset_end got=%h exp=%h", got, ov_t'('0));
    else n_pass++;
    mem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (got !== vfetch(1'b0)) $display("FAIL reset_release got=%h exp=%h", got, vfetch(1'b0));
    else n_pass++;
    @(posedge clock); #1;
  endtask

  task automatic test_li();
    ov_t e; st_t s; int k = 0;
    ov_t w;
    w = vs(4'd5); w.rw = 1'b1; w.wbs = 2'd2;
    push(5'h00, 1'b1, 1'b0, vfetch(1'b1));
    push(5'h00, 1'b1, 1'b0, vs(4'd1));
    push(5'h00, 1'b1, 1'b0, w);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); opcode = s.op; mem_ready = s.rdy; alu_zero = s.z;
      @(negedge clock); e = exp_q.pop_front(); n_chk++;
      if (got !== e) $display("FAIL li cyc%0d got=%h exp=%h", k, got, e); else n_pass++;
      k++; @(posedge clock); #1;
    end
  endtask

  task automatic test_add();
    ov_t e; st_t s; int k = 0;
    ov_t w;
    w = vs(4'd5); w.rw = 1'b1;
    push(5'h01, 1'b1, 1'b0, vfetch(1'b1));
    push(5'h01, 1'b1, 1'b0, vs(4'd1));
    push(5'h01, 1'b1, 1'b0, vs(4'd2));
    push(5'h01, 1'b1, 1'b0, w);
    e = vs(4'd2); e.aop = 3'd1;
    push(5'h03, 1'b1, 1'b0, vfetch(1'b1));
    push(5'h03, 1'b1, 1'b0, vs(4'd1));
    push(5'h03, 1'b1, 1'b0, e);
    push(5'h03, 1'b1, 1'b0, w);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); opcode = s.op; mem_ready = s.rdy; alu_zero = s.z;
      @(negedge clock); e = exp_q.pop_front(); n_chk++;
      if (got !== e) $display("FAIL add_sub cyc%0d got=%h exp=%h", k, got, e); else n_pass++;
      k++; @(posedge clock); #1;
    end
  endtask

  task automatic test_fetch_wait();
    ov_t e; st_t s; int k = 0;
    ov_t x, w;
    x = vs(4'd2); x.srcb = 2'd1;
    w = vs(4'd5); w.rw = 1'b1;
    for (int i = 0; i < 3; i++) push(5'h02, 1'b0, 1'b0, vfetch(1'b0));
    push(5'h02, 1'b1, 1'b0, vfetch(1'b1));
    push(5'h02, 1'b1, 1'b0, vs(4'd1));
    push(5'h02, 1'b1, 1'b0, x);
    push(5'h02, 1'b1, 1'b0, w);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); opcode = s.op; mem_ready = s.rdy; alu_zero = s.z;
      @(negedge clock); e = exp_q.pop_front(); n_chk++;
      if (got !== e) $display("FAIL fetch_wait cyc%0d got=%h exp=%h", k, got, e); else n_pass++;
      k++; @(posedge clock); #1;
    end
  endtask

  task automatic test_push_pop();
    ov_t e; st_t s; int k = 0;
    ov_t x, m, r, w;
    x = vs(4'd2); x.aop = 3'd1; x.srcb = 2'd2; x.spw = 1'b1;
    m = vs(4'd4); m.mwr = 1'b1; m.iord = 2'd2;
    r = vs(4'd3); r.mrd = 1'b1; r.iord = 2'd2;
    w = vs(4'd5); w.rw = 1'b1; w.wbs = 2'd1; w.spw = 1'b1; w.srcb = 2'd2;
    push(5'h06, 1'b1, 1'b0, vfetch(1'b1));
    push(5'h06, 1'b1, 1'b0, vs(4'd1));
    push(5'h06, 1'b1, 1'b0, x);
    push(5'h06, 1'b1, 1'b0, m);
    push(5'h07, 1'b1, 1'b0, vfetch(1'b1));
    push(5'h07, 1'b1, 1'b0, vs(4'd1));
    push(5'h07, 1'b1, 1'b0, r);
    push(5'h07, 1'b1, 1'b0, w);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); opcode = s.op; mem_ready = s.rdy; alu_zero = s.z;
      @(negedge clock); e = exp_q.pop_front(); n_chk++;
      if (got !== e) $display("FAIL push_pop cyc%0d got=%h exp=%h", k, got, e); else n_pass++;
      k++; @(posedge clock); #1;
    end
  endtask

  task automatic test_beq();
    ov_t e; st_t s; int k = 0;
    ov_t x0, x1;
    x0 = vs(4'd2); x0.aop = 3'd1; x0.pcs = 2'd3;
    x1 = x0; x1.pcw = 1'b1;
    push(5'h0A, 1'b1, 1'b0, vfetch(1'b1));
    push(5'h0A, 1'b1, 1'b0, vs(4'd1));
    push(5'h0A, 1'b1, 1'b0, x0);
    push(5'h0A, 1'b1, 1'b1, vfetch(1'b1));
    push(5'h0A, 1'b1, 1'b1, vs(4'd1));
    push(5'h0A, 1'b1, 1'b1, x1);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); opcode = s.op; mem_ready = s.rdy; alu_zero = s.z;
      @(negedge clock); e = exp_q.pop_front(); n_chk++;
      if (got !== e) $display("FAIL beq cyc%0d got=%h exp=%h", k, got, e); else n_pass++;
      k++; @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    ov_t e; st_t s; int k = 0;
    ov_t j, r, x, m, w;
    j = vs(4'd2); j.rw = 1'b1; j.wbs = 2'd3; j.pcw = 1'b1; j.pcs = 2'd1;
    r = vs(4'd2); r.pcw = 1'b1; r.pcs = 2'd2;
    x = vs(4'd2); x.srcb = 2'd1;
    m = vs(4'd3); m.mrd = 1'b1; m.iord = 2'd1;
    w = vs(4'd5); w.rw = 1'b1; w.wbs = 2'd1;
    push(5'h08, 1'b1, 1'b0, vfetch(1'b1));
    push(5'h08, 1'b1, 1'b0, vs(4'd1));
    push(5'h08, 1'b1, 1'b0, j);
    push(5'h09, 1'b1, 1'b0, vfetch(1'b1));
    push(5'h09, 1'b1, 1'b0, vs(4'd1));
    push(5'h09, 1'b1, 1'b0, r);
    push(5'h04, 1'b1, 1'b0, vfetch(1'b1));
    push(5'h04, 1'b1, 1'b0, vs(4'd1));
    push(5'h04, 1'b1, 1'b0, x);
    push(5'h04, 1'b0, 1'b0, m);
    push(5'h04, 1'b1, 1'b0, m);
    push(5'h04, 1'b1, 1'b0, w);
    push(5'h00, 1'b0, 1'b0, vfetch(1'b0));
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); opcode = s.op; mem_ready = s.rdy; alu_zero = s.z;
      @(negedge clock); e = exp_q.pop_front(); n_chk++;
      if (got !== e) $display("FAIL back_to_back cyc%0d got=%h exp=%h", k, got, e); else n_pass++;
      k++; @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_memwr();
    ov_t e; st_t s; int k = 0;
    ov_t x, m;
    x = vs(4'd2); x.srcb = 2'd1;
    m = vs(4'd4); m.mwr = 1'b1; m.iord = 2'd1;
    push(5'h05, 1'b1, 1'b0, vfetch(1'b1));
    push(5'h05, 1'b1, 1'b0, vs(4'd1));
    push(5'h05, 1'b1, 1'b0, x);
    push(5'h05, 1'b0, 1'b0, m);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); opcode = s.op; mem_ready = s.rdy; alu_zero = s.z;
      @(negedge clock); e = exp_q.pop_front(); n_chk++;
      if (got !== e) $display("FAIL sw cyc%0d got=%h exp=%h", k, got, e); else n_pass++;
      k++; @(posedge clock); #1;
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if (mem_write !== 1'b0) $display("FAIL reset_memwr_strobe got=%b exp=0", mem_write);
    else n_pass++;
    n_chk++;
    if (got !== '0) $display("FAIL reset_memwr_all got=%h exp=%h", got, ov_t'('0));
    else n_pass++;
    @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #1;
    n_chk++;
    if (got !== vfetch(1'b0)) $display("FAIL reset_memwr_fetch got=%h exp=%h", got, vfetch(1'b0));
    else n_pass++;
  endtask

  task automatic test_halt();
    ov_t e; st_t s; int k = 0;
    ov_t h;
    h = vs(4'd6); h.hlt = 1'b1;
    push(5'h1F, 1'b1, 1'b0, vfetch(1'b1));
    push(5'h1F, 1'b1, 1'b0, vs(4'd1));
    for (int i = 0; i < 3; i++) push(5'h00, 1'b1, 1'b1, h);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); opcode = s.op; mem_ready = s.rdy; alu_zero = s.z;
      @(negedge clock); e = exp_q.pop_front(); n_chk++;
      if (got !== e) $display("FAIL halt cyc%0d got=%h exp=%h", k, got, e); else n_pass++;
      k++; @(posedge clock); #1;
    end
    do_reset();
  endtask

  task automatic test_illegal();
    ov_t e; st_t s; int k = 0;
    ov_t t;
    t = vs(4'd7); t.hlt = 1'b1;
    push(5'h10, 1'b1, 1'b0, vfetch(1'b1));
    push(5'h10, 1'b1, 1'b0, vs(4'd1));
`ifdef FRANKIE_ILLEGAL_TRAP_EN
    push(5'h00, 1'b1, 1'b0, t);
    push(5'h00, 1'b1, 1'b0, t);
`else
    push(5'h00, 1'b0, 1'b0, vfetch(1'b0));
    push(5'h00, 1'b1, 1'b0, vfetch(1'b1));
`endif
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); opcode = s.op; mem_ready = s.rdy; alu_zero = s.z;
      @(negedge clock); e = exp_q.pop_front(); n_chk++;
      if (got !== e) $display("FAIL illegal cyc%0d got=%h exp=%h", k, got, e); else n_pass++;
      k++; @(posedge clock); #1;
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_li();
    test_add();
    test_fetch_wait();
    test_push_pop();
    test_beq();
    test_back_to_back();
    test_reset_memwr();
    test_halt();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
